charge_sched: RTL and testbench

Scheduler for the coin-operated charging station: holds per-bay coin credit, arbitrates round-robin between bays requesting a charge, and sequences the single shared charger through load, minute countdown and release. It sits between the coin/button front end and the charger drive and display, replacing per-bay state codes with a grant bus and BCD minute/credit readouts.

---
 rtl/charge_pkg.sv | 39 +++
 rtl/charge_sched_if.sv | 35 +++
 rtl/charge_credit.sv | 53 +++++
 rtl/charge_sched.sv | 148 ++++++++++++++
 tb/tb_charge_sched.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/charge_pkg.sv
// Shared types, tariff constants and helpers for the charging-station scheduler.
package charge_pkg;

  localparam int CREDIT_W = 5;
  localparam int MIN_W    = 6;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = 5'd20;

  localparam logic [MIN_W-1:0] TARIFF_5  = 6'd5;
  localparam logic [MIN_W-1:0] TARIFF_10 = 6'd10;
  localparam logic [MIN_W-1:0] TARIFF_15 = 6'd30;
  localparam logic [MIN_W-1:0] TARIFF_20 = 6'd40;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHARGE, ST_DONE} state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  function automatic logic [MIN_W-1:0] tariff(input logic [CREDIT_W-1:0] credit);
    case (credit)
      5'd5:    tariff = TARIFF_5;
      5'd10:   tariff = TARIFF_10;
      5'd15:   tariff = TARIFF_15;
      5'd20:   tariff = TARIFF_20;
      default: tariff = '0;
    endcase
  endfunction

  // Values never exceed 63, so the tens digit always fits in 4 bits.
  function automatic bcd_t to_bcd(input logic [MIN_W-1:0] v);
    logic [MIN_W-1:0] t;
    t            = v / MIN_W'(10);
    to_bcd.tens  = 4'(t);
    to_bcd.units = 4'(v - t * MIN_W'(10));
  endfunction

endpackage

// File: rtl/charge_sched_if.sv
// Front-end / display bus of the charge scheduler. CHARGE_REFUND_EN adds the refund outputs.
interface charge_sched_if #(parameter int NPORT = 2);
  import charge_pkg::*;

  logic [NPORT-1:0] coin5;
  logic [NPORT-1:0] coin10;
  logic [NPORT-1:0] start;
  logic [NPORT-1:0] cancel;
  logic [1:0]       disp_sel;
  logic [NPORT-1:0] grant;
  logic             on;
  logic [NPORT-1:0] reject;
  logic [3:0]       min2;
  logic [3:0]       min1;
  logic [3:0]       money2;
  logic [3:0]       money1;

`ifdef CHARGE_REFUND_EN
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amt;

  modport master (output coin5, coin10, start, cancel, disp_sel,
                  input  grant, on, reject, min2, min1, money2, money1,
                         refund_valid, refund_amt);
  modport slave  (input  coin5, coin10, start, cancel, disp_sel,
                  output grant, on, reject, min2, min1, money2, money1,
                         refund_valid, refund_amt);
`else
  modport master (output coin5, coin10, start, cancel, disp_sel,
                  input  grant, on, reject, min2, min1, money2, money1);
  modport slave  (input  coin5, coin10, start, cancel, disp_sel,
                  output grant, on, reject, min2, min1, money2, money1);
`endif

endinterface

// File: rtl/charge_credit.sv
// Per-bay coin credit: add/overflow-reject, request latch, clear on load or cancel.
module charge_credit
  import charge_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                start,
  input  logic                cancel,
  input  logic                load,
  output logic [CREDIT_W-1:0] credit,
  output logic                req,
  output logic                reject
);

  logic [CREDIT_W-1:0] add;
  logic [CREDIT_W:0]   sum;
  logic                over;

  always_comb begin
    add = '0;
    if (coin5)  add = add + CREDIT_W'(5);
    if (coin10) add = add + CREDIT_W'(10);
    sum  = {1'b0, credit} + {1'b0, add};
    over = sum > {1'b0, CREDIT_MAX};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= '0;
      req    <= 1'b0;
      reject <= 1'b0;
    end else begin
      reject <= 1'b0;
      if (cancel) begin
        credit <= '0;
        req    <= 1'b0;
      end else if (load) begin
        // a coin landing in the load cycle is kept as fresh credit
        credit <= add;
        req    <= 1'b0;
      end else begin
        if (coin5 || coin10) begin
          if (over) reject <= 1'b1;
          else      credit <= sum[CREDIT_W-1:0];
        end
        if (start && credit != '0) req <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/charge_sched.sv
// Round-robin charge scheduler: one shared charger, per-bay credit, minute countdown.
// Optional refund on cancel when CHARGE_REFUND_EN is defined.
module charge_sched
  import charge_pkg::*;
#(
  parameter int NPORT    = 2,
  parameter int TICK_DIV = 60
)(
  input  logic          clk,
  input  logic          rst,
  charge_sched_if.slave bus
);

  localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int PS_W  = $clog2(TICK_DIV);

  typedef logic [IDX_W-1:0] idx_t;

  state_e                            state;
  idx_t                              sel, ptr, pick;
  logic                              found;
  logic [NPORT-1:0][CREDIT_W-1:0]    credit;
  logic [NPORT-1:0]                  req, elig, load;
  logic [MIN_W-1:0]                  remaining;
  logic [PS_W-1:0]                   presc;
  logic [CREDIT_W-1:0]               shown;
  bcd_t                              min_bcd, money_bcd;
`ifdef CHARGE_REFUND_EN
  logic                              sess_long;
`endif

  for (genvar i = 0; i < NPORT; i++) begin : g_bay
    charge_credit u_credit (
      .clk    (clk),
      .rst    (rst),
      .coin5  (bus.coin5[i]),
      .coin10 (bus.coin10[i]),
      .start  (bus.start[i]),
      .cancel (bus.cancel[i]),
      .load   (load[i]),
      .credit (credit[i]),
      .req    (req[i]),
      .reject (bus.reject[i])
    );
    // a start in the same cycle counts, so LOAD follows the start edge directly
    assign elig[i] = (req[i] | bus.start[i]) & (credit[i] != '0) & ~bus.cancel[i];
    assign load[i] = (state == ST_LOAD) && (sel == idx_t'(i));
  end

  // Scan from ptr upward; descending loop so the nearest bay is written last.
  always_comb begin
    idx_t j;
    j     = '0;
    pick  = ptr;
    found = 1'b0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      j = idx_t'((int'(ptr) + k) % NPORT);
      if (elig[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= '0;
      ptr       <= '0;
      remaining <= '0;
      presc     <= '0;
      bus.grant <= '0;
      bus.on    <= 1'b0;
`ifdef CHARGE_REFUND_EN
      sess_long        <= 1'b0;
      bus.refund_valid <= 1'b0;
      bus.refund_amt   <= '0;
`endif
    end else begin
`ifdef CHARGE_REFUND_EN
      bus.refund_valid <= 1'b0;
      bus.refund_amt   <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (found) begin
            sel   <= pick;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (bus.cancel[sel]) begin
            state <= ST_DONE;
          end else begin
            bus.grant <= NPORT'(1) << sel;
            bus.on    <= 1'b1;
            remaining <= tariff(credit[sel]);
            presc     <= '0;
`ifdef CHARGE_REFUND_EN
            sess_long <= tariff(credit[sel]) > TARIFF_10;
`endif
            state     <= ST_CHARGE;
          end
        end
        ST_CHARGE: begin
          if (bus.cancel[sel]) begin
            bus.on    <= 1'b0;
            remaining <= '0;
            state     <= ST_DONE;
`ifdef CHARGE_REFUND_EN
            bus.refund_valid <= 1'b1;
            bus.refund_amt   <= sess_long ? CREDIT_W'(remaining >> 1) : CREDIT_W'(remaining);
`endif
          end else if (presc == PS_W'(TICK_DIV - 1)) begin
            presc     <= '0;
            remaining <= remaining - 1'b1;
            if (remaining == MIN_W'(1)) begin
              bus.on <= 1'b0;
              state  <= ST_DONE;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        ST_DONE: begin
          bus.grant <= '0;
          ptr       <= (sel == idx_t'(NPORT - 1)) ? '0 : sel + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shown = '0;
    for (int k = 0; k < NPORT; k++)
      if (bus.disp_sel == 2'(k)) shown = credit[k];
  end

  assign min_bcd    = to_bcd(remaining);
  assign money_bcd  = to_bcd(MIN_W'(shown));
  assign bus.min2   = min_bcd.tens;
  assign bus.min1   = min_bcd.units;
  assign bus.money2 = money_bcd.tens;
  assign bus.money1 = money_bcd.units;

endmodule

// File: tb/tb_charge_sched.sv
// Scoreboard bench for charge_sched: grant/on/reject transitions are queued with their cycle.
module tb_charge_sched;

  localparam int NP = 2;
  localparam int TD = 4;

  typedef struct {
    int         at;
    logic [4:0] snap;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  ev_t  got_ev;
  logic [4:0] prev = '0;
  logic [4:0] cur;

  charge_sched_if #(.NPORT(NP)) bus();

  charge_sched #(.NPORT(NP), .TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of {grant,on,reject} must match the next queued event.
  always @(negedge clk) begin
    cur = {bus.grant, bus.on, bus.reject};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got=%b", cyc, cur);
      end else begin
        got_ev = exp_q.pop_front();
        if (cur !== got_ev.snap || cyc != got_ev.at) begin
          failures++;
          $display("FAIL event got=%b@%0d expected=%b@%0d", cur, cyc, got_ev.snap, got_ev.at);
        end
      end
      prev = cur;
    end
  end

  task automatic clr();
    bus.coin5  = '0;
    bus.coin10 = '0;
    bus.start  = '0;
    bus.cancel = '0;
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int at, input logic [1:0] g, input logic o, input logic [1:0] rj);
    exp_q.push_back('{at, {g, o, rj}});
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, expv);
    end
  endtask

  initial begin
    int e;
    rst = 1'b1;
    clr();
    bus.disp_sel = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_grant_on", 8'({bus.grant, bus.on}), 8'h00);
    chk("rst_reject",   8'(bus.reject),          8'h00);
    chk("rst_min",      {bus.min2, bus.min1},     8'h00);
    chk("rst_money",    {bus.money2, bus.money1}, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Round robin: both bays 5 credit, start together; bay0 re-queues while charging.
    bus.coin5 = 2'b11;
    step();
    chk("rr_money", {bus.money2, bus.money1}, 8'h05);
    bus.start = 2'b11;
    e = cyc + 1;
    push(e + 1,  2'b01, 1'b1, 2'b00);
    push(e + 21, 2'b01, 1'b0, 2'b00);
    push(e + 22, 2'b00, 1'b0, 2'b00);
    push(e + 24, 2'b10, 1'b1, 2'b00);
    push(e + 44, 2'b10, 1'b0, 2'b00);
    push(e + 45, 2'b00, 1'b0, 2'b00);
    push(e + 47, 2'b01, 1'b1, 2'b00);
    push(e + 67, 2'b01, 1'b0, 2'b00);
    push(e + 68, 2'b00, 1'b0, 2'b00);
    step();
    wait_until(e + 3);
    bus.coin5 = 2'b01;
    step();
    bus.start = 2'b01;
    step();
    chk("requeue_money", {bus.money2, bus.money1}, 8'h05);
    wait_until(e + 24);
    chk("bay1_min", {bus.min2, bus.min1}, 8'h05);
    wait_until(e + 70);

    // Bay0 15 credit -> 30 minutes.
    bus.coin10 = 2'b01;
    step();
    chk("money_10", {bus.money2, bus.money1}, 8'h10);
    bus.coin5 = 2'b01;
    step();
    chk("money_15", {bus.money2, bus.money1}, 8'h15);
    bus.start = 2'b01;
    e = cyc + 1;
    push(e + 1,   2'b01, 1'b1, 2'b00);
    push(e + 121, 2'b01, 1'b0, 2'b00);
    push(e + 122, 2'b00, 1'b0, 2'b00);
    step();
    wait_until(e + 1);
    chk("min_30",        {bus.min2, bus.min1},     8'h30);
    chk("money_cleared", {bus.money2, bus.money1}, 8'h00);
    wait_until(e + 4);
    chk("min_pre_tick",  {bus.min2, bus.min1},     8'h30);
    wait_until(e + 5);
    chk("min_29",        {bus.min2, bus.min1},     8'h29);
    wait_until(e + 125);

    // Overflow reject on bay1.
    bus.disp_sel = 2'd1;
    bus.coin10 = 2'b10;
    step();
    bus.coin5 = 2'b10;
    step();
    chk("bay1_15", {bus.money2, bus.money1}, 8'h15);
    bus.coin10 = 2'b10;
    e = cyc + 1;
    push(e,     2'b00, 1'b0, 2'b10);
    push(e + 1, 2'b00, 1'b0, 2'b00);
    step();
    step();
    chk("reject_keeps", {bus.money2, bus.money1}, 8'h15);
    bus.coin5 = 2'b10;
    step();
    chk("bay1_20", {bus.money2, bus.money1}, 8'h20);
    bus.disp_sel = 2'd0;
    bus.coin5 = 2'b01;
    bus.coin10 = 2'b01;
    step();
    chk("coin_both", {bus.money2, bus.money1}, 8'h15);
    bus.cancel = 2'b11;
    step();
    chk("cancel_bay0", {bus.money2, bus.money1}, 8'h00);
    bus.disp_sel = 2'd1;
    #1;
    chk("cancel_bay1", {bus.money2, bus.money1}, 8'h00);

    // Start with no credit is ignored.
    bus.start = 2'b11;
    step();
    repeat (4) @(negedge clk);
    chk("zero_credit", 8'({bus.grant, bus.on}), 8'h00);

    // Cancel: other bay first, then active bay with 7 of 10 minutes left.
    bus.disp_sel = 2'd0;
    bus.coin5 = 2'b01;
    bus.coin10 = 2'b10;
    step();
    chk("bay0_5", {bus.money2, bus.money1}, 8'h05);
    bus.start = 2'b10;
    e = cyc + 1;
    push(e + 1,  2'b10, 1'b1, 2'b00);
    push(e + 14, 2'b10, 1'b0, 2'b00);
    push(e + 15, 2'b00, 1'b0, 2'b00);
    step();
    wait_until(e + 5);
    bus.cancel = 2'b01;
    step();
    chk("other_cancel", {bus.money2, bus.money1}, 8'h00);
    wait_until(e + 13);
    chk("min_07", {bus.min2, bus.min1}, 8'h07);
    bus.cancel = 2'b10;
    step();
`ifdef CHARGE_REFUND_EN
    chk("refund", {2'b00, bus.refund_valid, bus.refund_amt}, 8'h27);
`endif
    wait_until(e + 18);

    // Asynchronous reset mid-charge.
    bus.disp_sel = 2'd1;
    bus.coin10 = 2'b01;
    bus.coin5 = 2'b10;
    step();
    bus.start = 2'b01;
    e = cyc + 1;
    push(e + 1, 2'b01, 1'b1, 2'b00);
    step();
    wait_until(e + 5);
    chk("pre_rst_min",   {bus.min2, bus.min1},     8'h09);
    chk("pre_rst_money", {bus.money2, bus.money1}, 8'h05);
    push(e + 6, 2'b00, 1'b0, 2'b00);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out",   8'({bus.grant, bus.on}), 8'h00);
    chk("async_rst_min",   {bus.min2, bus.min1},     8'h00);
    chk("async_rst_money", {bus.money2, bus.money1}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
